// File: rtl/intlv_pkg.sv
// intlv_pkg: shared definitions for the 802.11a block interleaver.
//   - mode_t: modulation encodings carried on the 'mod' port
//   - per-mode N_CBPS / D / s constants and lookup helpers
//   - BANK_DEPTH / BANK_AW: symbol bank size, selected by INTLV_64QAM_EN
// Build option: define INTLV_64QAM_EN for 288-bit banks and 64-QAM support;
// otherwise banks are 192 bits and mod=3 is treated as 16-QAM.
package intlv_pkg;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_16QAM = 2'd2,
        MOD_64QAM = 2'd3
    } mode_t;

    localparam logic [8:0] N_BPSK  = 9'd48;
    localparam logic [8:0] N_QPSK  = 9'd96;
    localparam logic [8:0] N_16QAM = 9'd192;
    localparam logic [8:0] N_64QAM = 9'd288;

    localparam logic [4:0] D_BPSK  = 5'd3;
    localparam logic [4:0] D_QPSK  = 5'd6;
    localparam logic [4:0] D_16QAM = 5'd12;
    localparam logic [4:0] D_64QAM = 5'd18;

`ifdef INTLV_64QAM_EN
    localparam int unsigned BANK_DEPTH = 288;
`else
    localparam int unsigned BANK_DEPTH = 192;
`endif
    localparam int unsigned BANK_AW = $clog2(BANK_DEPTH);

    // Mode actually processed for a given port value.
    function automatic mode_t eff_mode(input logic [1:0] m);
`ifdef INTLV_64QAM_EN
        return mode_t'(m);
`else
        return (m == 2'd3) ? MOD_16QAM : mode_t'(m);
`endif
    endfunction

    function automatic logic [8:0] mode_n(input mode_t m);
        logic [8:0] n;
        n = N_BPSK;
        case (m)
            MOD_QPSK:  n = N_QPSK;
            MOD_16QAM: n = N_16QAM;
            MOD_64QAM: n = N_64QAM;
            default:   n = N_BPSK;
        endcase
        return n;
    endfunction

    function automatic logic [4:0] mode_d(input mode_t m);
        logic [4:0] d;
        d = D_BPSK;
        case (m)
            MOD_QPSK:  d = D_QPSK;
            MOD_16QAM: d = D_16QAM;
            MOD_64QAM: d = D_64QAM;
            default:   d = D_BPSK;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] mode_s(input mode_t m);
        logic [1:0] s;
        s = 2'd1;
        case (m)
            MOD_16QAM: s = 2'd2;
            MOD_64QAM: s = 2'd3;
            default:   s = 2'd1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/intlv_addr_gen.sv
// intlv_addr_gen: combinational write-address generator.
//   col  in  4  k mod 16
//   row  in  5  k / 16
//   mode in  2  latched mode of the bank being written
//   j    out BANK_AW  bank address holding input bit k
// i = D*col + row ; j = s*floor(i/s) + ((i + N - col) mod s)
module intlv_addr_gen
    import intlv_pkg::*;
(
    input  logic [3:0]         col,
    input  logic [4:0]         row,
    input  mode_t              mode,
    output logic [BANK_AW-1:0] j
);

    logic [8:0] n;
    logic [4:0] d;
    logic [1:0] s;
    logic [8:0] i;
    logic [9:0] t;
    logic [8:0] q3;
    logic [1:0] r3;
    logic [8:0] j9;

    always_comb begin
        n  = mode_n(mode);
        d  = mode_d(mode);
        s  = mode_s(mode);
        i  = {4'b0, d} * {5'b0, col} + {4'b0, row};
        // floor(16*i/N) equals col here, so the rotation term uses col directly
        t  = {1'b0, i} + {1'b0, n} - {6'b0, col};
        q3 = i / 9'd3;
        r3 = 2'(t % 10'd3);
        case (s)
            2'd2:    j9 = {i[8:1], t[0]};
            2'd3:    j9 = q3 * 9'd3 + {7'b0, r3};
            default: j9 = i;
        endcase
    end

    assign j = BANK_AW'(j9);

endmodule

// File: rtl/interleaver.sv
// interleaver: bit-serial 802.11a block interleaver with ping-pong banks.
//   Clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   mod       in   modulation, sampled with bit 0 of each symbol
//   in_valid  in   coded bit present
//   in_bit    in   coded bit
//   in_ready  out  write bank available
//   out_valid out  permuted bit present
//   out_bit   out  permuted bit
//   out_ready in   downstream accepts bit
//   sym_start out  first output bit of a symbol
// Build option: INTLV_64QAM_EN (see intlv_pkg).
module interleaver
    import intlv_pkg::*;
#(
    parameter int unsigned NBANK = 2
)(
    input  logic       Clk,
    input  logic       reset,
    input  logic [1:0] mod,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    input  logic       out_ready,
    output logic       sym_start
);

    logic [BANK_DEPTH-1:0] bank [NBANK];
    mode_t                 bank_mode [NBANK];
    logic [NBANK-1:0]      full;
    logic                  wptr;
    logic                  rptr;
    logic [3:0]            col;
    logic [4:0]            row;
    logic [BANK_AW-1:0]    rd_cnt;

    mode_t                 wr_mode;
    logic                  first_bit;
    logic                  last_wr;
    logic                  last_rd;
    logic                  wr_en;
    logic                  rd_en;
    logic [BANK_AW-1:0]    wr_addr;

    // The mode for bit 0 comes straight from the port; later bits use the
    // value captured into bank_mode when bit 0 was written.
    always_comb begin
        first_bit = (col == '0) && (row == '0);
        wr_mode   = first_bit ? eff_mode(mod) : bank_mode[wptr];
        last_wr   = (col == 4'd15) && (row == mode_d(wr_mode) - 5'd1);
        last_rd   = rd_cnt == BANK_AW'(mode_n(bank_mode[rptr]) - 9'd1);
    end

    assign in_ready  = ~full[wptr];
    assign out_valid = full[rptr];
    assign wr_en     = in_valid & in_ready;
    assign rd_en     = out_valid & out_ready;
    assign out_bit   = out_valid & bank[rptr][rd_cnt];
    assign sym_start = out_valid & (rd_cnt == '0);

    intlv_addr_gen u_addr_gen (
        .col  (col),
        .row  (row),
        .mode (wr_mode),
        .j    (wr_addr)
    );

    // Write and read sides always target different banks, so a release and
    // a fill on the same edge update independent flag bits.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            col    <= '0;
            row    <= '0;
            rd_cnt <= '0;
            full   <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            for (int unsigned b = 0; b < NBANK; b++) begin
                bank_mode[b] <= MOD_BPSK;
            end
        end else begin
            if (wr_en) begin
                if (first_bit) begin
                    bank_mode[wptr] <= eff_mode(mod);
                end
                if (last_wr) begin
                    col        <= '0;
                    row        <= '0;
                    full[wptr] <= 1'b1;
                    wptr       <= ~wptr;
                end else if (col == 4'd15) begin
                    col <= '0;
                    row <= row + 5'd1;
                end else begin
                    col <= col + 4'd1;
                end
            end
            if (rd_en) begin
                if (last_rd) begin
                    rd_cnt     <= '0;
                    full[rptr] <= 1'b0;
                    rptr       <= ~rptr;
                end else begin
                    rd_cnt <= rd_cnt + BANK_AW'(1);
                end
            end
        end
    end

    // Bank contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            bank[wptr][wr_addr] <= in_bit;
        end
    end

endmodule

// File: tb/tb_interleaver.sv
module tb_interleaver;

    logic       Clk = 1'b0;
    logic       reset;
    logic [1:0] mod;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_ready;
    logic       sym_start;

    interleaver dut (
        .Clk       (Clk),
        .reset     (reset),
        .mod       (mod),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_ready (out_ready),
        .sym_start (sym_start)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_q[$];   // {first, bit}

    int  bubbles;
    int  stalls;
    int  accepted;
    int  first_stall_at;
    int  pos;
    int  ones;
    int  one_pos;
    logic prev_hold;
    logic prev_bit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int model_mode(input int m);
`ifdef INTLV_64QAM_EN
        return m;
`else
        return (m == 3) ? 2 : m;
`endif
    endfunction

    function automatic int model_n(input int m);
        int bpsc [4] = '{1, 2, 4, 6};
        return 48 * bpsc[m];
    endfunction

    // Output position of input bit k (802.11a two-step permutation).
    function automatic int perm_pos(input int m, input int k);
        int n, s, i;
        n = model_n(m);
        s = (m == 3) ? 3 : (m == 2) ? 2 : 1;
        i = (n / 16) * (k % 16) + k / 16;
        return s * (i / s) + (i + n - (16 * i) / n) % s;
    endfunction

    // one_pos < 0 : random payload; chg : disturb mod after bit 0
    task automatic send_sym(input int m, input int one_pos_in, input int nbits, input bit chg);
        logic [287:0] d;
        logic         expb [288];
        int           me, n, waited;
        logic         rdy;
        me = model_mode(m);
        n  = model_n(me);
        for (int k = 0; k < 288; k++)
            d[k] = (one_pos_in >= 0) ? (k == one_pos_in) : 1'($urandom);
        for (int k = 0; k < nbits; k++) begin
            in_valid = 1'b1;
            in_bit   = d[k];
            mod      = (k == 0 || !chg) ? m[1:0] : ~m[1:0];
            waited   = 0;
            forever begin
                @(negedge Clk);
                rdy = in_ready;
                @(posedge Clk);
                #1;
                if (rdy) break;
                stalls++;
                if (first_stall_at < 0) first_stall_at = accepted;
                waited++;
                if (waited > 2000) begin
                    check("in_ready_timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
            end
            accepted++;
        end
        in_valid = 1'b0;
        if (nbits == n) begin
            for (int k = 0; k < n; k++) expb[perm_pos(me, k)] = d[k];
            for (int p = 0; p < n; p++) exp_q.push_back({p == 0, expb[p]});
        end
    endtask

    task automatic drain();
        int cnt = 0;
        while ((exp_q.size() > 0 || out_valid) && cnt < 3000) begin
            @(negedge Clk);
            cnt++;
        end
        check("drain_timeout", cnt < 3000, 1);
        @(posedge Clk);
        #1;
    endtask

    // Output monitor / scoreboard
    always @(negedge Clk) begin
        logic [1:0] e;
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_bit", out_bit, prev_bit);
            end
            if (!out_valid && exp_q.size() > 0) bubbles++;
            if (!out_valid) check("idle_zero", {sym_start, out_bit}, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bit", out_bit, e[0]);
                    check("sym_start", sym_start, e[1]);
                    if (e[1]) begin
                        pos  = 0;
                        ones = 0;
                    end
                    if (out_bit) begin
                        ones++;
                        one_pos = pos;
                    end
                    pos++;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_bit  = out_bit;
        end
    end

    task automatic single_one(input string tag, input int m, input int k, input int exp_pos, input bit chg);
        send_sym(m, k, model_n(model_mode(m)), chg);
        drain();
        check({tag, "_pos"}, one_pos, exp_pos);
        check({tag, "_ones"}, ones, 1);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; mod = 2'd0; out_ready = 1'b1;
        bubbles = 0; stalls = 0; accepted = 0; first_stall_at = -1;
        pos = 0; ones = 0; one_pos = -1; prev_hold = 1'b0; prev_bit = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_sym_start", sym_start, 0);
        reset = 1'b1;
        @(posedge Clk); #1;

        single_one("bpsk_k1", 0, 1, 3, 0);
        single_one("bpsk_k16", 0, 16, 1, 1);
        single_one("qam16_k1", 2, 1, 13, 0);
        single_one("qam16_k0", 2, 0, 0, 1);
`ifdef INTLV_64QAM_EN
        single_one("qam64_k1", 3, 1, 20, 0);
        single_one("qam64_k2", 3, 2, 37, 0);
`else
        single_one("mod3_k1", 3, 1, 13, 0);
        single_one("mod3_k2", 3, 2, 24, 0);
`endif

        // back-to-back QPSK, downstream always ready
        bubbles = 0; stalls = 0;
        repeat (4) send_sym(1, -1, 96, 0);
        drain();
        check("qpsk_stalls", stalls, 0);
        check("qpsk_bubbles", bubbles, 0);

        // downstream stalled for 200 cycles during a BPSK stream
        stalls = 0; accepted = 0; first_stall_at = -1;
        out_ready = 1'b0;
        fork
            repeat (4) send_sym(0, -1, 48, 0);
            begin
                repeat (200) @(posedge Clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_point", first_stall_at, 96);
        check("stall_accepted", accepted, 192);

        // reset mid-symbol with a full bank pending
        out_ready = 1'b0;
        send_sym(0, -1, 48, 0);
        send_sym(2, -1, 30, 0);
        reset = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge Clk); #1;
        reset = 1'b1;
        out_ready = 1'b1;
        send_sym(2, -1, 192, 0);
        drain();
        single_one("post_rst_bpsk", 0, 16, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
